// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO write port.
// Radix-2 shift-add multiply and restoring divide, one bit per RUN cycle.
//
// state | meaning
// IDLE  | waiting for start; operands captured on start
// PREP  | absolute values, result signs, counter load; div-by-zero shortcut
// RUN   | data_width iterations of shift-add / restoring subtract
// FIX   | apply result signs, latch hi_result / lo_result
// DONE  | one-cycle HI/LO write strobe
module muldiv_ctrl #(
    parameter int data_width = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [data_width-1:0] src_a,
    input  logic [data_width-1:0] src_b,
    input  logic                  flush,
    input  logic                  instr_uses_hi,
    input  logic                  instr_uses_lo,
    output logic                  busy,
    output logic                  stall,
    output logic [data_width-1:0] hi_result,
    output logic [data_width-1:0] lo_result,
    output logic                  hi_we,
    output logic                  lo_we,
    output logic                  div_by_zero
);
    localparam int W     = data_width;
    localparam int CNT_W = $clog2(data_width + 1);

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic [1:0]       op_q;
    logic [W-1:0]     a_q, b_q, opnd;
    logic [2*W-1:0]   acc;
    logic [CNT_W-1:0] cnt;
    logic             neg_lo, neg_hi, dbz;

    logic             is_div, is_signed, sign_a, sign_b, b_zero;
    logic [W-1:0]     abs_a, abs_b;
    logic [W:0]       mul_sum, rem_sh, diff;
    logic             ge;
    logic [2*W-1:0]   mul_nxt, div_nxt, prod;
    logic [W-1:0]     rem_fix, quo_fix, fix_hi, fix_lo;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign b_zero    = (b_q == '0);

    always_comb begin
        sign_a  = is_signed & a_q[W-1];
        sign_b  = is_signed & b_q[W-1];
        abs_a   = sign_a ? (~a_q + 1'b1) : a_q;
        abs_b   = sign_b ? (~b_q + 1'b1) : b_q;

        // multiplier sits in acc low half; product carry kept in an extra bit
        mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_nxt = {mul_sum, acc[W-1:1]};

        rem_sh  = acc[2*W-1:W-1];
        ge      = (rem_sh >= {1'b0, opnd});
        diff    = rem_sh - {1'b0, opnd};
        div_nxt = {(ge ? diff[W-1:0] : rem_sh[W-1:0]), acc[W-2:0], ge};

        prod    = neg_lo ? (~acc + 1'b1) : acc;
        rem_fix = neg_hi ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
        quo_fix = neg_lo ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
        fix_hi  = is_div ? rem_fix : prod[2*W-1:W];
        fix_lo  = is_div ? quo_fix : prod[W-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && !flush) state_nxt = PREP;
            PREP: begin
                if (flush)                state_nxt = IDLE;
                else if (is_div && b_zero) state_nxt = DONE;
                else                      state_nxt = RUN;
            end
            RUN: begin
                if (flush)                       state_nxt = IDLE;
                else if (cnt == CNT_W'(1))       state_nxt = FIX;
            end
            FIX:  state_nxt = flush ? IDLE : DONE;
            DONE: state_nxt = IDLE;   // committed write wins over flush
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            opnd      <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            dbz       <= 1'b0;
            hi_result <= '0;
            lo_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        op_q <= op;
                        a_q  <= src_a;
                        b_q  <= src_b;
                        dbz  <= 1'b0;
                    end
                end
                PREP: begin
                    cnt    <= CNT_W'(W);
                    opnd   <= is_div ? abs_b : abs_a;
                    acc    <= {{W{1'b0}}, (is_div ? abs_a : abs_b)};
                    neg_lo <= sign_a ^ sign_b;
                    neg_hi <= sign_a;
                    if (is_div && b_zero && !flush) begin
                        dbz       <= 1'b1;
                        hi_result <= a_q;
                        lo_result <= '1;
                    end
                end
                RUN: begin
                    acc <= is_div ? div_nxt : mul_nxt;
                    cnt <= cnt - CNT_W'(1);
                end
                FIX: begin
                    if (!flush) begin
                        hi_result <= fix_hi;
                        lo_result <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign stall       = busy & (instr_uses_hi | instr_uses_lo | start);
    assign hi_we       = (state == DONE);
    assign lo_we       = (state == DONE);
    assign div_by_zero = (state == DONE) & dbz;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, signed/unsigned results,
// divide-by-zero, stall hazards, flush and asynchronous reset.
module tb_muldiv_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0, src_b = '0;
    logic        flush = 1'b0;
    logic        instr_uses_hi = 1'b0, instr_uses_lo = 1'b0;
    logic        busy, stall, hi_we, lo_we, div_by_zero;
    logic [31:0] hi_result, lo_result;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    muldiv_ctrl #(.data_width(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .instr_uses_hi(instr_uses_hi), .instr_uses_lo(instr_uses_lo),
        .busy(busy), .stall(stall), .hi_result(hi_result), .lo_result(lo_result),
        .hi_we(hi_we), .lo_we(lo_we), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    // Launch at a negedge; k counts cycles after the sampling edge T.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int k_strobe, output logic [31:0] hi, output logic [31:0] lo,
                          output logic dbz_o, output logic lo_we_o, output int busy_err,
                          output logic busy_after);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k_strobe = -1; busy_err = 0; hi = '0; lo = '0; dbz_o = 1'b0; lo_we_o = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (hi_we) begin
                k_strobe = k; hi = hi_result; lo = lo_result;
                dbz_o = div_by_zero; lo_we_o = lo_we;
                break;
            end
            if (!busy) busy_err++;
            @(negedge clock);
        end
        @(negedge clock);
        busy_after = busy;
    endtask

    task automatic test_reset();
        @(negedge clock); @(negedge clock);
        checks++;
        if ({busy, stall, hi_we, lo_we, div_by_zero} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, stall, hi_we, lo_we, div_by_zero});
        end
        checks++;
        if ({hi_result, lo_result} !== 64'h0) begin
            errors++; $display("FAIL reset_result: got %h expected 0", {hi_result, lo_result});
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_multu_latency();
        int k, be; logic [31:0] hi, lo; logic dz, lw, ba;
        run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, k, hi, lo, dz, lw, be, ba);
        checks++; if (k !== 35) begin errors++; $display("FAIL multu_strobe_cycle: got %0d expected 35", k); end
        checks++; if (be !== 0) begin errors++; $display("FAIL multu_busy: got %0d idle cycles expected 0", be); end
        checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
        checks++; if ({lw, dz} !== 2'b10) begin errors++; $display("FAIL multu_we_dbz: got %b expected 10", {lw, dz}); end
        checks++; if (ba !== 1'b0) begin errors++; $display("FAIL multu_busy_after: got %b expected 0", ba); end
    endtask

    task automatic test_signed();
        int k, be; logic [31:0] hi, lo; logic dz, lw, ba;
        logic [1:0]  ops[5] = '{MULT, DIV, DIV, DIVU, MULTU};
        logic [31:0] as[5]  = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'd7, 32'd100, 32'h00010000};
        logic [31:0] bs[5]  = '{32'd5, 32'd2, 32'hFFFFFFFE, 32'd7, 32'h00010000};
        logic [31:0] eh[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd2, 32'd1};
        logic [31:0] el[5]  = '{32'hFFFFFFF1, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd14, 32'd0};
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], k, hi, lo, dz, lw, be, ba);
            checks++;
            if ({hi, lo} !== {eh[i], el[i]} || k !== 35) begin
                errors++;
                $display("FAIL signed_vec%0d: got hi=%h lo=%h k=%0d expected hi=%h lo=%h k=35", i, hi, lo, k, eh[i], el[i]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int k, be; logic [31:0] hi, lo; logic dz, lw, ba;
        run_op(DIVU, 32'h12345678, 32'h0, k, hi, lo, dz, lw, be, ba);
        checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b expected 1", dz); end
        checks++; if ({hi, lo} !== {32'h12345678, 32'hFFFFFFFF}) begin
            errors++; $display("FAIL dbz_result: got %h_%h expected 12345678_ffffffff", hi, lo); end
        checks++; if (k !== 2) begin errors++; $display("FAIL dbz_cycle: got %0d expected 2", k); end
        run_op(DIV, 32'hFFFFFFFB, 32'h0, k, hi, lo, dz, lw, be, ba);
        checks++; if ({dz, hi, lo} !== {1'b1, 32'hFFFFFFFB, 32'hFFFFFFFF}) begin
            errors++; $display("FAIL dbz_signed: got %b %h %h expected 1 fffffffb ffffffff", dz, hi, lo); end
        run_op(DIV, 32'h80000000, 32'hFFFFFFFF, k, hi, lo, dz, lw, be, ba);
        checks++; if ({dz, hi, lo} !== {1'b0, 32'h0, 32'h80000000}) begin
            errors++; $display("FAIL div_overflow: got %b %h %h expected 0 00000000 80000000", dz, hi, lo); end
    endtask

    task automatic test_hazard();
        int bad; int k;
        instr_uses_lo = 1'b1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b expected 0", stall); end
        op = MULT; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
        @(negedge clock);
        start = 1'b0; bad = 0;
        for (int c = 1; c <= 35; c++) begin
            if (stall !== 1'b1) bad++;
            @(negedge clock);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_busy: got %0d low cycles expected 0", bad); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_after: got %b expected 0", stall); end
        instr_uses_lo = 1'b0;
        checks++; if (lo_result !== 32'd12) begin errors++; $display("FAIL hazard_mult: got %h expected 0000000c", lo_result); end

        op = MULTU; src_a = 32'd7; src_b = 32'd6; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        op = DIVU; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_start: got %b expected 1", stall); end
        @(negedge clock);
        start = 1'b0;
        k = -1;
        for (int c = 11; c <= 60; c++) begin
            if (hi_we) begin k = c; break; end
            @(negedge clock);
        end
        checks++; if (k !== 35 || {hi_result, lo_result} !== {32'd0, 32'd42}) begin
            errors++; $display("FAIL restart_ignored: got k=%0d %h_%h expected k=35 00000000_0000002a", k, hi_result, lo_result); end
        @(negedge clock);
    endtask

    task automatic test_flush();
        int we_cnt;
        op = MULTU; src_a = 32'h55; src_b = 32'h3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
        we_cnt = 0;
        repeat (40) begin @(negedge clock); if (hi_we || lo_we) we_cnt++; end
        checks++; if (we_cnt !== 0) begin errors++; $display("FAIL flush_no_write: got %0d strobes expected 0", we_cnt); end
        checks++; if (lo_result !== 32'd42) begin errors++; $display("FAIL flush_hold: got %h expected 0000002a", lo_result); end

        op = MULTU; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (34) @(negedge clock);
        flush = 1'b1;
        #1;
        checks++; if ({hi_we, lo_we, lo_result} !== {2'b11, 32'd15}) begin
            errors++; $display("FAIL flush_done: got %b%b %h expected 11 0000000f", hi_we, lo_we, lo_result); end
        @(negedge clock);
        flush = 1'b0;
        checks++; if ({busy, lo_result} !== {1'b0, 32'd15}) begin
            errors++; $display("FAIL flush_done_after: got %b %h expected 0 0000000f", busy, lo_result); end

        op = MULTU; src_a = 32'd2; src_b = 32'd2; start = 1'b1; flush = 1'b1;
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_idle: got %b expected 0", busy); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int we_cnt; int k, be; logic [31:0] hi, lo; logic dz, lw, ba;
        op = MULTU; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (19) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++; if ({busy, stall, hi_we, lo_we, div_by_zero, hi_result, lo_result} !== 69'h0) begin
            errors++; $display("FAIL reset_async: got %b%b%b%b%b %h %h expected all 0", busy, stall, hi_we, lo_we, div_by_zero, hi_result, lo_result); end
        @(negedge clock);
        reset = 1'b0;
        we_cnt = 0;
        repeat (40) begin @(negedge clock); if (hi_we || busy) we_cnt++; end
        checks++; if (we_cnt !== 0) begin errors++; $display("FAIL reset_no_strobe: got %0d expected 0", we_cnt); end
        run_op(DIVU, 32'd100, 32'd7, k, hi, lo, dz, lw, be, ba);
        checks++; if (k !== 35 || {hi, lo} !== {32'd2, 32'd14}) begin
            errors++; $display("FAIL reset_recover: got k=%0d %h_%h expected k=35 00000002_0000000e", k, hi, lo); end
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_multu_latency();
                test_signed();
                test_div_by_zero();
                test_hazard();
                test_flush();
                test_reset_mid();
            end
            begin
                #200000;
                errors++;
                $display("FAIL timeout: got no completion expected completion");
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Iterative multiply/divide sequencer that owns all writes into the HI/LO register pair for MULT, MULTU, DIV and DIVU. Decode launches an operation with a one-cycle start pulse; the block then runs a radix-2 shift-add or restoring-divide loop for data_width cycles and writes HI and LO in the same cycle. While it is busy, it stalls the decode stage whenever the instruction in decode reads HI/LO or tries to launch another operation.

Parameters:
data_width, 32, operand width; HI/LO width; number of iteration cycles

Ports:
clock  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  launch pulse from decode, sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; captured with start
src_a  input  data_width  rs value (multiplicand / dividend)
src_b  input  data_width  rt value (multiplier / divisor)
flush  input  1  abort the in-flight operation; no HI/LO write
instr_uses_hi  input  1  decode instruction reads HI (MFHI)
instr_uses_lo  input  1  decode instruction reads LO (MFLO)
busy  output  1  high in every state except IDLE
stall  output  1  freeze fetch/decode
hi_result  output  data_width  value to write into HI
lo_result  output  data_width  value to write into LO
hi_we  output  1  HI write strobe, one cycle
lo_we  output  1  LO write strobe, asserted with hi_we
div_by_zero  output  1  pulses with the write strobes when a DIV/DIVU has src_b == 0

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - All outputs are 0, including hi_result and lo_result.
  - Internal accumulator, operand and counter registers are cleared.
- States and transitions:
  - IDLE: on start, capture op, src_a and src_b, then go to PREP.
  - PREP (1 cycle):
    - Signed ops: take absolute values and record result signs (product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa).
    - Load the counter with data_width.
    - Divide with src_b == 0: set the dbz flag and go directly to DONE.
  - RUN (data_width cycles, counter decrements to 0):
    - Multiply: conditional add of the multiplicand into the upper half of a 2*data_width accumulator, then shift right 1.
    - Divide: shift remainder:quotient left 1; trial-subtract the divisor; if the difference is non-negative, keep it and set quotient bit 0.
  - FIX (1 cycle):
    - Two's-complement the product, quotient and/or remainder according to the recorded signs.
    - Latch hi_result and lo_result.
  - DONE (1 cycle):
    - Assert hi_we = lo_we = 1 (and div_by_zero if dbz).
    - Go to IDLE.
- Latency: with start sampled at edge T, the write strobes are high during cycle T+data_width+3, which is cycle 35 for the default width. The next start is accepted at the edge that ends DONE + 1, i.e. in IDLE.
- Results:
  - Multiply: HI:LO = full 2*data_width product.
  - Divide: LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - Divide by zero: LO = all ones, HI = src_a unmodified.
  - Signed overflow (0x80000000 / -1): LO = 0x80000000, HI = 0. This falls out of the natural datapath; it is not special-cased.
- hi_result and lo_result hold their last values until the next FIX; they are not cleared after DONE.
- stall = busy & (instr_uses_hi | instr_uses_lo | start). It is combinational and is also high during DONE, so MFHI/MFLO issue the cycle after the write.
- start while busy: ignored, no re-capture. Correct pipelines never do this, because stall holds the instruction.
- flush: in any non-IDLE state, go to IDLE on the next edge.
  - No write strobes are issued.
  - flush during DONE: the write still completes, because DONE has priority and the result is architecturally committed.
  - flush in IDLE: no effect.
  - flush together with start in IDLE: the start is discarded.
- Reset mid-operation: immediate return to IDLE with no write strobe.

Test Plan:
- MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF, start at T -> hi_we=lo_we=1 only in cycle T+35; hi_result=0xFFFFFFFE, lo_result=0x00000001; busy high from T+1 through T+35.
- MULT src_a=-3 (0xFFFFFFFD), src_b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV src_a=-7, src_b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU src_a=0x12345678, src_b=0 -> div_by_zero=1 with the strobes, LO=0xFFFFFFFF, HI=0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Hazard: start MULT, then hold instr_uses_lo=1 -> stall=1 every cycle through DONE and 0 in the following IDLE cycle. A second start pulsed mid-run -> stall=1 and the result is unchanged.
- Flush at T+10 -> busy=0 from T+11, no hi_we/lo_we ever. Flush asserted in DONE -> strobes still fire.
- Reset asserted asynchronously at T+20 -> all outputs 0 immediately, no strobe; a new start after reset release completes normally.
